// File: rtl/multi_pattern_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_pattern_sequencer                                                  |
// | N-channel order/pattern sequencer sharing one sync ROM (round-robin).    |
// | Optional build macro: PATSEQ_OVERRUN_EN (sticky dropped-strobe flags).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_pattern_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 8,
  parameter int ORDER_BASE = 0,
  parameter int ORDER_LEN  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_CH-1:0]     i_note_stb,
  output logic [NUM_CH-1:0]     o_note_valid,
  output logic [6*NUM_CH-1:0]   o_note_pitch,
  output logic [5*NUM_CH-1:0]   o_note_len,
  output logic [4*NUM_CH-1:0]   o_note_instrument,
  output logic [ADDR_W-1:0]     o_rom_addr,
  input  logic [15:0]           i_rom_data
`ifdef PATSEQ_OVERRUN_EN
  ,
  output logic [NUM_CH-1:0]     o_overrun
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OI_W = (ORDER_LEN > 1) ? $clog2(ORDER_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ORD_ADDR = 3'd1,
    S_ORD_DATA = 3'd2,
    S_PAT_ADDR = 3'd3,
    S_PAT_DATA = 3'd4,
    S_NOTE     = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0] pending, halted, in_pat;
  logic [OI_W-1:0]   order_idx [NUM_CH];
  logic [ADDR_W-1:0] pat_addr  [NUM_CH];
  logic [7:0]        pat_len   [NUM_CH];
  logic [7:0]        pat_cnt   [NUM_CH];
  logic [5:0]        pitch     [NUM_CH];
  logic [4:0]        len       [NUM_CH];
  logic [3:0]        instr     [NUM_CH];

  logic [CH_W-1:0]   grant, last_grant, arb_ch, cand;
  logic              arb_found;
  logic [ADDR_W-1:0] ord_addr;

  // Rotating search starting just after the previous grant.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    cand      = last_grant;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(cand) == NUM_CH - 1) ? '0 : cand + 1'b1;
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_ch    = cand;
      end
    end
  end

  assign ord_addr = ADDR_W'(ORDER_BASE + int'(grant) * ORDER_LEN + int'(order_idx[grant]));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_rom_addr   = '0;
    o_note_valid = '0;
    unique case (state)
      S_IDLE:
        if (arb_found) state_nxt = in_pat[arb_ch] ? S_PAT_ADDR : S_ORD_ADDR;
      S_ORD_ADDR: begin
        o_rom_addr = ord_addr;
        state_nxt  = S_ORD_DATA;
      end
      S_ORD_DATA:
        if (i_rom_data[15:8] == 8'd0)
          state_nxt = (order_idx[grant] == '0) ? S_IDLE : S_ORD_ADDR;
        else
          state_nxt = S_PAT_ADDR;
      S_PAT_ADDR: begin
        o_rom_addr = pat_addr[grant];
        state_nxt  = S_PAT_DATA;
      end
      S_PAT_DATA: state_nxt = S_NOTE;
      S_NOTE: begin
        o_note_valid[grant] = 1'b1;
        state_nxt           = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending    <= '0;
      halted     <= '0;
      in_pat     <= '0;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        order_idx[c] <= '0;
        pat_addr[c]  <= '0;
        pat_len[c]   <= '0;
        pat_cnt[c]   <= '0;
        pitch[c]     <= '0;
        len[c]       <= '0;
        instr[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (i_note_stb[c] && !halted[c] && !pending[c]) pending[c] <= 1'b1;
      unique case (state)
        S_IDLE:
          if (arb_found) begin
            grant           <= arb_ch;
            last_grant      <= arb_ch;
            pending[arb_ch] <= 1'b0;
          end
        S_ORD_DATA:
          if (i_rom_data[15:8] == 8'd0) begin
            // An empty first entry means the channel has nothing to play.
            if (order_idx[grant] == '0) halted[grant]    <= 1'b1;
            else                        order_idx[grant] <= '0;
          end else begin
            pat_addr[grant] <= ADDR_W'(i_rom_data[7:0]);
            pat_len[grant]  <= i_rom_data[15:8];
            pat_cnt[grant]  <= 8'd1;
            in_pat[grant]   <= 1'b1;
          end
        S_PAT_DATA: begin
          pitch[grant] <= i_rom_data[5:0];
          len[grant]   <= i_rom_data[10:6];
          instr[grant] <= i_rom_data[14:11];
        end
        S_NOTE:
          if (pat_cnt[grant] < pat_len[grant]) begin
            pat_addr[grant] <= pat_addr[grant] + 1'b1;
            pat_cnt[grant]  <= pat_cnt[grant] + 8'd1;
          end else begin
            in_pat[grant]    <= 1'b0;
            order_idx[grant] <= (int'(order_idx[grant]) == ORDER_LEN - 1) ?
                                '0 : order_idx[grant] + 1'b1;
          end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_note_out
    assign o_note_pitch[6*c +: 6]      = pitch[c];
    assign o_note_len[5*c +: 5]        = len[c];
    assign o_note_instrument[4*c +: 4] = instr[c];
  end

`ifdef PATSEQ_OVERRUN_EN
  logic [NUM_CH-1:0] overrun;
  logic              busy;

  assign busy = (state == S_ORD_ADDR) || (state == S_ORD_DATA) ||
                (state == S_PAT_ADDR) || (state == S_PAT_DATA);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (i_note_stb[c] && (pending[c] || (busy && grant == CH_W'(c))))
          overrun[c] <= 1'b1;
    end
  end

  assign o_overrun = overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_pattern_sequencer.sv
`default_nettype none
// Self-checking bench for multi_pattern_sequencer: transaction-level model
// plus directed scenarios and randomized strobe traffic.
module tb_multi_pattern_sequencer;
  localparam int NUM_CH = 4, ADDR_W = 8, ORDER_BASE = 0, ORDER_LEN = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   note_stb;
  logic [NUM_CH-1:0]   note_valid;
  logic [6*NUM_CH-1:0] note_pitch;
  logic [5*NUM_CH-1:0] note_len;
  logic [4*NUM_CH-1:0] note_instr;
  logic [ADDR_W-1:0]   rom_addr;
  logic [15:0]         rom_data;
  logic [15:0]         rom [256];
`ifdef PATSEQ_OVERRUN_EN
  logic [NUM_CH-1:0]   overrun;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  multi_pattern_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ORDER_BASE(ORDER_BASE), .ORDER_LEN(ORDER_LEN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_note_stb(note_stb),
    .o_note_valid(note_valid), .o_note_pitch(note_pitch), .o_note_len(note_len),
    .o_note_instrument(note_instr), .o_rom_addr(rom_addr), .i_rom_data(rom_data)
`ifdef PATSEQ_OVERRUN_EN
    , .o_overrun(overrun)
`endif
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int valid_cnt [NUM_CH];

  // Model: per-channel sequencing state plus one service "transaction".
  bit [NUM_CH-1:0] m_pending, m_halted, m_overrun;
  int   m_last;
  bit   m_in_pat [NUM_CH];
  int   m_oidx [NUM_CH], m_paddr [NUM_CH], m_plen [NUM_CH], m_pcnt [NUM_CH];
  logic [5:0] m_pitch [NUM_CH];
  logic [4:0] m_len [NUM_CH];
  logic [3:0] m_instr [NUM_CH];
  bit   s_active, s_emit;
  int   s_ch, s_j, s_L;
  int   s_addr [8];
  logic [15:0] s_note;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = '0; m_halted = '0; m_overrun = '0; m_last = NUM_CH - 1;
    s_active = 0; s_emit = 0; s_ch = 0; s_j = 0; s_L = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_in_pat[c] = 0; m_oidx[c] = 0; m_paddr[c] = 0; m_plen[c] = 0; m_pcnt[c] = 0;
      m_pitch[c] = '0; m_len[c] = '0; m_instr[c] = '0;
    end
  endtask

  // Resolve a whole grant up front: address trace, length and resulting note.
  task automatic start_service(input int c);
    logic [15:0] w;
    bit halt;
    int a;
    halt = 0;
    s_active = 1; s_ch = c; s_j = 1; s_L = 0; s_emit = 0;
    for (int k = 0; k < 8; k++) s_addr[k] = 0;
    m_last = c;
    if (!m_in_pat[c]) begin
      for (int k = 0; k < 2; k++) begin
        a = (ORDER_BASE + c * ORDER_LEN + m_oidx[c]) % 256;
        s_addr[s_L + 1] = a;
        s_L += 2;
        w = rom[a];
        if (w[15:8] == 8'd0) begin
          if (m_oidx[c] == 0) begin halt = 1; break; end
          m_oidx[c] = 0;
        end else begin
          m_paddr[c] = int'(w[7:0]); m_plen[c] = int'(w[15:8]);
          m_pcnt[c] = 1; m_in_pat[c] = 1;
          break;
        end
      end
    end
    if (!halt) begin
      s_addr[s_L + 1] = m_paddr[c];
      s_L += 3;
      s_emit = 1;
      s_note = rom[m_paddr[c]];
      if (m_pcnt[c] < m_plen[c]) begin
        m_paddr[c] = (m_paddr[c] + 1) % 256;
        m_pcnt[c]++;
      end else begin
        m_in_pat[c] = 0;
        m_oidx[c] = (m_oidx[c] + 1) % ORDER_LEN;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [NUM_CH-1:0] s);
    bit [NUM_CH-1:0] np;
    bit in_srv;
    int c;
    if (r) begin model_reset(); return; end
    np = m_pending;
    for (int k = 0; k < NUM_CH; k++) begin
      in_srv = s_active && s_ch == k && !(s_emit && s_j == s_L);
      if (s[k] && (m_pending[k] || in_srv)) m_overrun[k] = 1;
      if (s[k] && !m_halted[k]) np[k] = 1;
    end
    if (s_active) begin
      if (s_j == s_L) begin
        s_active = 0;
        if (!s_emit) m_halted[s_ch] = 1;
      end else begin
        s_j++;
        if (s_emit && s_j == s_L) begin
          m_pitch[s_ch] = s_note[5:0];
          m_len[s_ch]   = s_note[10:6];
          m_instr[s_ch] = s_note[14:11];
        end
      end
    end else if (m_pending != '0) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        c = (m_last + i) % NUM_CH;
        if (m_pending[c]) break;
      end
      np[c] = 0;
      start_service(c);
    end
    m_pending = np;
  endtask

  task automatic tick(input logic r, input logic [NUM_CH-1:0] s);
    logic [NUM_CH-1:0]   ev;
    logic [6*NUM_CH-1:0] ep;
    logic [5*NUM_CH-1:0] el;
    logic [4*NUM_CH-1:0] ei;
    rst = r; note_stb = s;
    @(posedge clk); #1;
    cyc++;
    model_step(r, s);
    ev = '0;
    if (s_active && s_emit && s_j == s_L) ev[s_ch] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      ep[6*c +: 6] = m_pitch[c]; el[5*c +: 5] = m_len[c]; ei[4*c +: 4] = m_instr[c];
      if (note_valid[c] === 1'b1) valid_cnt[c]++;
    end
    check("note_valid", 64'(note_valid), 64'(ev));
    check("rom_addr", 64'(rom_addr), s_active ? 64'(s_addr[s_j]) : 64'd0);
    check("note_pitch", 64'(note_pitch), 64'(ep));
    check("note_len", 64'(note_len), 64'(el));
    check("note_instrument", 64'(note_instr), 64'(ei));
`ifdef PATSEQ_OVERRUN_EN
    check("overrun", 64'(overrun), 64'(m_overrun));
`endif
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    logic [NUM_CH-1:0] v;
    v = '0; v[ch] = 1'b1;
    return v;
  endfunction

  // Latency counts the strobe cycle as 1; -1 when no pulse within budget.
  task automatic strobe_and_wait(input int ch, input int budget, output int lat);
    tick(1'b0, onehot(ch));
    lat = 1;
    while (note_valid[ch] !== 1'b1 && lat < budget) begin
      tick(1'b0, '0);
      lat++;
    end
    if (note_valid[ch] !== 1'b1) lat = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  task automatic do_reset();
    tick(1'b1, '0); tick(1'b1, '0);
    for (int c = 0; c < NUM_CH; c++) valid_cnt[c] = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int t [NUM_CH];
    logic [5:0] p1;
    for (int a = 0; a < 256; a++) rom[a] = '0;
    rst = 1'b1; note_stb = '0;
    do_reset();
    check("reset_valid", 64'(note_valid), 64'd0);
    check("reset_rom_addr", 64'(rom_addr), 64'd0);

    // Scenario 1: two notes from one pattern, then the next order entry.
    rom[0] = 16'h020A; rom[1] = 16'h0130;
    rom[10] = 16'h0841; rom[11] = 16'h1042; rom[8'h30] = 16'h18C3;
    strobe_and_wait(0, 20, lat);
    check("t1_lat_new_entry", 64'(lat), 64'd6);
    check("t1_pitch0", 64'(note_pitch[5:0]), 64'd1);
    check("t1_len0", 64'(note_len[4:0]), 64'd1);
    check("t1_instr0", 64'(note_instr[3:0]), 64'd1);
    idle(10 - lat);
    strobe_and_wait(0, 20, lat);
    check("t1_lat_mid_pattern", 64'(lat), 64'd4);
    check("t1_pitch1", 64'(note_pitch[5:0]), 64'd2);
    check("t1_len1", 64'(note_len[4:0]), 64'd1);
    check("t1_instr1", 64'(note_instr[3:0]), 64'd2);
    idle(4);
    // Scenario 5: order_idx advanced to 1; reset lands on PAT_DATA.
    tick(1'b0, 4'b0001); tick(1'b0, '0);
    check("t1_order_idx1_addr", 64'(rom_addr), 64'd1);
    idle(3);
    tick(1'b1, '0);
    check("t5_rst_valid", 64'(note_valid), 64'd0);
    check("t5_rst_addr", 64'(rom_addr), 64'd0);
    check("t5_rst_pitch", 64'(note_pitch), 64'd0);
    strobe_and_wait(0, 20, lat);
    check("t5_restart_lat", 64'(lat), 64'd6);
    check("t5_restart_pitch", 64'(note_pitch[5:0]), 64'd1);

    // Scenario 2: simultaneous strobes served round-robin.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      rom[2*c] = {8'd1, 8'(8'h40 + c)};
      rom[2*c+1] = {8'd1, 8'(8'h40 + c)};
      rom[8'h40 + c] = 16'(c + 5);
      t[c] = -1;
    end
    tick(1'b0, '1);
    for (int n = 2; n <= 40; n++) begin
      tick(1'b0, '0);
      for (int c = 0; c < NUM_CH; c++)
        if (note_valid[c] === 1'b1 && t[c] < 0) t[c] = n;
    end
    for (int c = 0; c < NUM_CH; c++) check("t2_rr_time", 64'(t[c]), 64'(6 + 6*c));

    // Scenario 3: empty second entry wraps to entry 0.
    do_reset();
    rom[2] = 16'h0114; rom[3] = 16'h0000; rom[8'h14] = 16'h2A85;
    strobe_and_wait(1, 20, lat);
    check("t3_lat1", 64'(lat), 64'd6);
    check("t3_pitch1", 64'(note_pitch[11:6]), 64'd5);
    p1 = note_pitch[11:6];
    idle(3);
    strobe_and_wait(1, 20, lat);
    check("t3_lat_restart", 64'(lat), 64'd8);
    check("t3_same_pitch", 64'(note_pitch[11:6]), 64'(p1));
    check("t3_len", 64'(note_len[9:5]), 64'd10);
    check("t3_instr", 64'(note_instr[7:4]), 64'd5);

    // Scenario 4: channel 2 halts on an empty first entry.
    do_reset();
    rom[4] = 16'h0000; rom[6] = 16'h0150; rom[8'h50] = 16'h0001;
    strobe_and_wait(2, 30, lat);
    check("t4_halted_no_note", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    strobe_and_wait(2, 30, lat);
    check("t4_still_halted", 64'(valid_cnt[2]), 64'd0);
    strobe_and_wait(3, 20, lat);
    check("t4_other_ch", 64'(lat), 64'd6);
    rom[4] = 16'h0150;
    do_reset();
    strobe_and_wait(2, 20, lat);
    check("t4_after_reset", 64'(lat), 64'd6);

`ifdef PATSEQ_OVERRUN_EN
    // Scenario 6: back-to-back strobes on one channel.
    do_reset();
    tick(1'b0, 4'b0001); tick(1'b0, 4'b0001);
    idle(20);
    check("t6_overrun", 64'(overrun[0]), 64'd1);
    check("t6_one_note", 64'(valid_cnt[0]), 64'd1);
    idle(5);
    check("t6_sticky", 64'(overrun[0]), 64'd1);
`endif

    // Randomized traffic against the model, fresh ROM per round.
    for (int round = 0; round < 3; round++) begin
      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
      for (int a = 0; a < NUM_CH * ORDER_LEN; a++)
        rom[ORDER_BASE + a] = ($urandom_range(0, 7) == 0) ? 16'h0000 :
            {8'($urandom_range(1, 4)), 8'($urandom_range(8, 255))};
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        logic [NUM_CH-1:0] s;
        for (int c = 0; c < NUM_CH; c++) s[c] = ($urandom_range(0, 2) == 0);
        tick(($urandom_range(0, 399) == 0), s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
